// File: rtl/ws2812_strip_driver.sv
// WS2812 single-wire strip driver: sends one 24-bit colour to every pixel, GRB order, MSB first.
// A frame is sent once after reset and again whenever the colour word differs from the last one sent.
module ws2812_strip_driver #(
   parameter int NUM_LEDS = 60,
   parameter int T0H      = 20,
   parameter int T1H      = 40,
   parameter int T_BIT    = 62,
   parameter int T_RESET  = 15000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] color,
   output logic        dout,
   output logic        busy,
   output logic        frame_done
);

   localparam int TMAX = (T_BIT > T_RESET) ? T_BIT : T_RESET;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam int LW   = $clog2(NUM_LEDS + 1);

   typedef enum logic [1:0] {IDLE, BIT, LATCH} state_t;

   state_t          state_q, state_d;
   logic [23:0]     sr_q, sr_d;
   logic [23:0]     shadow_q, shadow_d;
   logic            pending_q, pending_d;
   logic [LW-1:0]   led_cnt_q, led_cnt_d;
   logic [4:0]      bit_cnt_q, bit_cnt_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            dout_q, dout_d;
   logic            busy_q, busy_d;
   logic            frame_done_q, frame_done_d;

   logic [23:0]     grb_latched;
   logic            bit_high;

   // Reloads between pixels use the colour captured at frame start, never the live input.
   assign grb_latched = {shadow_q[15:8], shadow_q[23:16], shadow_q[7:0]};
   assign bit_high    = sr_q[23] ? (timer_q < TW'(T1H)) : (timer_q < TW'(T0H));

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
      state_d      = state_q;
      sr_d         = sr_q;
      shadow_d     = shadow_q;
      pending_d    = pending_q;
      led_cnt_d    = led_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      timer_d      = timer_q;
      dout_d       = 1'b0;
      busy_d       = (state_q != IDLE);
      frame_done_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pending_q || (color != shadow_q)) begin
               sr_d      = {color[15:8], color[23:16], color[7:0]};
               shadow_d  = color;
               pending_d = 1'b0;
               led_cnt_d = '0;
               bit_cnt_d = '0;
               timer_d   = '0;
               state_d   = BIT;
            end
         end
         BIT: begin
            dout_d = bit_high;
            if (timer_q == TW'(T_BIT - 1)) begin
               timer_d = '0;
               if (bit_cnt_q == 5'd23) begin
                  bit_cnt_d = '0;
                  sr_d      = grb_latched;
                  led_cnt_d = led_cnt_q + 1'b1;
                  if (led_cnt_q == LW'(NUM_LEDS - 1)) state_d = LATCH;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  sr_d      = {sr_q[22:0], 1'b0};
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         LATCH: begin
            if (timer_q == TW'(T_RESET - 1)) begin
               timer_d      = '0;
               frame_done_d = 1'b1;
               state_d      = IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         sr_q         <= '0;
         shadow_q     <= '0;
         pending_q    <= 1'b1;
         led_cnt_q    <= '0;
         bit_cnt_q    <= '0;
         timer_q      <= '0;
         dout_q       <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sr_q         <= sr_d;
         shadow_q     <= shadow_d;
         pending_q    <= pending_d;
         led_cnt_q    <= led_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         timer_q      <= timer_d;
         dout_q       <= dout_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign dout       = dout_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ws2812_strip_driver.sv
// Bench for ws2812_strip_driver: captures each busy window of dout and compares it with a
// waveform built directly from the colour, pixel count and bit timing.
module tb_ws2812_strip_driver;

   localparam int NL   = 2;
   localparam int T0   = 2;
   localparam int T1   = 4;
   localparam int TB   = 6;
   localparam int TR   = 10;
   localparam int FLEN = NL * 24 * TB + TR;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [23:0] color = '0;
   logic        dout, busy, frame_done;

   int n_tests = 0;
   int n_fail  = 0;

   ws2812_strip_driver #(
      .NUM_LEDS(NL), .T0H(T0), .T1H(T1), .T_BIT(TB), .T_RESET(TR)
   ) dut (
      .clk(clk), .reset(reset), .color(color),
      .dout(dout), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference waveform: every pixel sends G,R,B MSB first, each bit high Th then low, then the gap.
   function automatic logic [FLEN-1:0] exp_wave(input logic [23:0] c);
      logic [FLEN-1:0] w;
      logic [23:0]     grb;
      int              th;
      w   = '0;
      grb = {c[15:8], c[23:16], c[7:0]};
      for (int p = 0; p < NL; p++)
         for (int b = 23; b >= 0; b--) begin
            th = grb[b] ? T1 : T0;
            for (int t = 0; t < TB; t++) w = {w[FLEN-2:0], (t < th)};
         end
      for (int t = 0; t < TR; t++) w = {w[FLEN-2:0], 1'b0};
      return w;
   endfunction

   // Monitor: one record per busy window.
   logic [FLEN-1:0] frames_q[$];
   int              len_q[$];
   int              fdcnt_q[$];
   bit              fdlast_q[$];
   int              busy_cycles = 0;
   int              idle_dout_hi = 0;

   initial begin
      logic [FLEN-1:0] cur_w;
      int              cur_len, fd_cnt;
      bit              fd_last, prev_busy;
      cur_w = '0; cur_len = 0; fd_cnt = 0; fd_last = 0; prev_busy = 0;
      forever begin
         @(negedge clk);
         if (busy === 1'b1) begin
            busy_cycles++;
            cur_w = {cur_w[FLEN-2:0], dout};
            cur_len++;
            fd_last = (frame_done === 1'b1);
            if (fd_last) fd_cnt++;
         end else begin
            if (dout === 1'b1) idle_dout_hi++;
            if (prev_busy) begin
               frames_q.push_back(cur_w);
               len_q.push_back(cur_len);
               fdcnt_q.push_back(fd_cnt);
               fdlast_q.push_back(fd_last);
               cur_w = '0; cur_len = 0; fd_cnt = 0; fd_last = 0;
            end
         end
         prev_busy = (busy === 1'b1);
      end
   end

   task automatic wait_frame(input string tag, output bit ok);
      int n;
      n = 0;
      while (frames_q.size() == 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      ok = (frames_q.size() > 0);
      if (!ok) check({tag, "_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic check_frame(input string tag, input logic [23:0] c);
      bit              ok;
      logic [FLEN-1:0] w;
      wait_frame(tag, ok);
      if (ok) begin
         w = frames_q.pop_front();
         check({tag, "_busy_len"}, 64'(len_q.pop_front()), 64'(FLEN));
         check({tag, "_wave_bad_bits"}, 64'($countones(w ^ exp_wave(c))), 64'd0);
         check({tag, "_fd_pulses"}, 64'(fdcnt_q.pop_front()), 64'd1);
         check({tag, "_fd_last"}, 64'(fdlast_q.pop_front()), 64'd1);
      end
   endtask

   task automatic wait_busy(input string tag);
      int n;
      n = 0;
      while (busy !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_busy_rise"}, 64'(busy), 64'd1);
   endtask

   initial begin
      logic [23:0] prev_c, c;
      int          bc0;
      bit          ok;

      // Reset values.
      repeat (3) @(negedge clk);
      check("rst_dout", 64'(dout), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_fd", 64'(frame_done), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      check("start_latency_busy_low", 64'(busy), 64'd0);
      @(negedge clk);
      check("start_latency_busy_high", 64'(busy), 64'd1);
      check("start_latency_dout_high", 64'(dout), 64'd1);
      check_frame("post_reset", 24'h000000);

      // Bit order: red only.
      color = 24'hFF0000;
      check_frame("red", 24'hFF0000);

      // Mid-frame changes: A then B at bit 10 then C at bit 30; only A and C are sent.
      color = 24'h123456;
      wait_busy("mid");
      repeat (10 * TB) @(negedge clk);
      color = 24'hABCDEF;
      repeat (20 * TB) @(negedge clk);
      color = 24'h0F1E2D;
      check_frame("midA", 24'h123456);
      check_frame("midC", 24'h0F1E2D);

      // Unchanged colour: nothing more is sent.
      bc0 = busy_cycles;
      repeat (500) @(negedge clk);
      check("nochange_busy_cycles", 64'(busy_cycles - bc0), 64'd0);
      check("nochange_frames", 64'(frames_q.size()), 64'd0);
      check("nochange_dout", 64'(dout), 64'd0);

      // Random colours.
      prev_c = 24'h0F1E2D;
      for (int i = 0; i < 4; i++) begin
         do c = 24'($urandom); while (c == prev_c);
         color = c;
         check_frame($sformatf("rand%0d", i), c);
         prev_c = c;
      end

      // Reset during pixel 1 aborts the frame; a full frame follows.
      do c = 24'($urandom); while (c == prev_c);
      color = c;
      wait_busy("abort");
      repeat (24 * TB + 20) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_dout", 64'(dout), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      reset = 1'b0;
      wait_frame("abort_partial", ok);
      if (ok) begin
         void'(frames_q.pop_front());
         check("abort_partial_short", 64'(len_q.pop_front() < FLEN), 64'd1);
         void'(fdcnt_q.pop_front());
         void'(fdlast_q.pop_front());
      end
      @(negedge clk);
      check("restart_busy_low", 64'(busy), 64'd0);
      @(negedge clk);
      check("restart_busy_high", 64'(busy), 64'd1);
      check_frame("after_abort", c);

      // Single low bit: only the B LSB is a long pulse.
      color = 24'h000001;
      check_frame("single_bit", 24'h000001);

      repeat (20) @(negedge clk);
      check("idle_dout_high_cycles", 64'(idle_dout_hi), 64'd0);
      check("leftover_frames", 64'(frames_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "global timeout");
   end

endmodule
